main_control_fsm: RTL and testbench
===================================

Name: main_control_fsm

Overview:
- Multicycle MIPS main control unit.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps, driving datapath enables and muxes.
- Generates the 2-bit aluOp consumed by the downstream ALU control decoder:
  - 00: add
  - 01: subtract
  - 10: decode funct
- Sits between the instruction register opcode field and the datapath/memory interface.

Parameters:
- OP_RTYPE, 6'h00, R-type opcode
- OP_LW, 6'h23, load word opcode
- OP_SW, 6'h2B, store word opcode
- OP_BEQ, 6'h04, branch-equal opcode
- OP_J, 6'h02, jump opcode
- OP_ADDI, 6'h08, add-immediate opcode

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- opcode  input  6  instr[31:26] from the instruction register
- memReady  input  1  memory has completed the current read/write this cycle
- pcWrite  output  1  unconditional PC load
- pcWriteCond  output  1  PC load qualified by ALU zero (datapath ANDs it)
- iorD  output  1  memory address select: 0=PC, 1=ALUOut
- memRead  output  1  memory read request
- memWrite  output  1  memory write request
- irWrite  output  1  instruction register load
- memToReg  output  1  register write data: 0=ALUOut, 1=MDR
- regDst  output  1  destination register: 0=rt, 1=rd
- regWrite  output  1  register file write enable
- aluSrcA  output  1  0=PC, 1=A
- aluSrcB  output  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
- aluOp  output  2  00 add, 01 sub, 10 funct
- pcSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
- state  output  4  current state encoding, for debug

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. While reset is high, state=FETCH(0).
- Outputs:
  - Outputs are Moore decodes of state, except irWrite and pcWrite in FETCH and the MEMRD/MEMWR advance, which are additionally gated by memReady.
  - Any output not listed for a state is 0.
- States and required outputs:
  - FETCH(0): memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00, irWrite=memReady, pcWrite=memReady. Stay while !memReady; go to DECODE when memReady.
  - DECODE(1): aluSrcA=0, aluSrcB=11, aluOp=00 (branch target precompute). Next state by opcode:
    - LW or SW -> MEMADR
    - RTYPE -> EXEC
    - BEQ -> BRANCH
    - J -> JUMP
    - ADDI -> ADDIEX
    - other -> FETCH (see Optional Feature)
  - MEMADR(2): aluSrcA=1, aluSrcB=10, aluOp=00. LW -> MEMRD; SW -> MEMWR.
  - MEMRD(3): memRead=1, iorD=1. Stay while !memReady; go to MEMWB when memReady.
  - MEMWB(4): regWrite=1, memToReg=1, regDst=0. Go to FETCH.
  - MEMWR(5): memWrite=1, iorD=1. Stay while !memReady; go to FETCH when memReady.
  - EXEC(6): aluSrcA=1, aluSrcB=00, aluOp=10. Go to ALUWB.
  - ALUWB(7): regWrite=1, regDst=1, memToReg=0. Go to FETCH.
  - BRANCH(8): aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01. Go to FETCH.
  - ADDIEX(9): aluSrcA=1, aluSrcB=10, aluOp=00. Go to ADDIWB.
  - ADDIWB(10): regWrite=1, regDst=0, memToReg=0. Go to FETCH.
  - JUMP(11): pcWrite=1, pcSource=10. Go to FETCH.
  - Encodings 12-15: unreachable; if entered, go to FETCH next cycle with all outputs 0.
- Latency with memReady tied high, counted in cycles including FETCH:
  - R-type: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
  - J: 3
  - ADDI: 4
  - Each memReady-low cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Reset mid-operation: state returns to FETCH immediately and asynchronously. Write strobes (regWrite, memWrite, pcWrite, pcWriteCond) drop in the same delta. No partial writeback completes.
- opcode is sampled only in DECODE and MEMADR. The datapath holds IR stable after FETCH, so opcode changes in other states are ignored.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- When defined:
  - Adds state TRAP(12) and output illegalOp (1 bit).
  - DECODE with an unrecognised opcode goes to TRAP.
  - TRAP asserts illegalOp=1, all other outputs 0, and holds until reset.
- When undefined:
  - No illegalOp port.
  - An unrecognised opcode returns to FETCH as a no-op, with no register or memory write.

Test Plan:
- Reset high, memReady=1 -> state=0, memRead=1, irWrite=1, pcWrite=1, aluSrcB=01, regWrite=0, memWrite=0. Reset asserted while in MEMWB -> regWrite falls with no clock edge.
- opcode=6'h00, memReady=1 -> states 0,1,6,7,0. aluOp=10 in EXEC. regWrite=1 and regDst=1 only in ALUWB.
- opcode=6'h23, memReady low for 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0. memToReg=1 and regWrite=1 only in state 4.
- opcode=6'h2B, then opcode=6'h04 -> SW: memWrite=1, iorD=1 for exactly one cycle. BEQ: aluOp=01, pcWriteCond=1, pcSource=01 in state 8, then FETCH.
- opcode=6'h02 then 6'h08 -> JUMP: pcWrite=1, pcSource=10 in state 11. ADDI: states 9,10 with aluSrcB=10 and regDst=0.
- opcode=6'h3F -> without macro: 0,1,0 with no writes. With ILLEGAL_OP_TRAP_EN: state=12 and illegalOp=1 held for 10+ cycles, cleared only by reset.

Source files
------------

// File: rtl/main_control_fsm.sv
// ---------------------------------------------------------------------------
// main_control_fsm
//
// Main control unit for a multicycle MIPS datapath. Each instruction steps
// through fetch, decode, execute, memory and writeback states. The unit
// drives the datapath enables and mux selects for each state. It also
// generates the 2-bit aluOp (00 add, 01 sub, 10 decode funct) that feeds the
// ALU control decoder.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset (state returns to FETCH)
//   opcode       instr[31:26] from the instruction register
//   memReady     memory completed the current read/write this cycle
//   pcWrite      unconditional PC load
//   pcWriteCond  PC load qualified by ALU zero in the datapath
//   iorD         memory address select: 0=PC, 1=ALUOut
//   memRead      memory read request
//   memWrite     memory write request
//   irWrite      instruction register load
//   memToReg     register write data: 0=ALUOut, 1=MDR
//   regDst       destination register: 0=rt, 1=rd
//   regWrite     register file write enable
//   aluSrcA      0=PC, 1=A
//   aluSrcB      00=B, 01=4, 10=signext imm, 11=signext imm<<2
//   aluOp        00 add, 01 sub, 10 funct
//   pcSource     00=ALU result, 01=ALUOut, 10=jump target
//   state        current state encoding, for debug
//   illegalOp    (ILLEGAL_OP_TRAP_EN only) high while trapped
//
// Build option:
//   ILLEGAL_OP_TRAP_EN  adds the TRAP state and the illegalOp output. An
//                       unrecognised opcode then parks the FSM in TRAP
//                       until reset. Without it, such an opcode completes
//                       as a no-op and the FSM returns to FETCH.
// ---------------------------------------------------------------------------
module main_control_fsm #(
   parameter logic [5:0] OP_RTYPE = 6'h00,
   parameter logic [5:0] OP_LW    = 6'h23,
   parameter logic [5:0] OP_SW    = 6'h2B,
   parameter logic [5:0] OP_BEQ   = 6'h04,
   parameter logic [5:0] OP_J     = 6'h02,
   parameter logic [5:0] OP_ADDI  = 6'h08
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       memReady,
   output logic       pcWrite,
   output logic       pcWriteCond,
   output logic       iorD,
   output logic       memRead,
   output logic       memWrite,
   output logic       irWrite,
   output logic       memToReg,
   output logic       regDst,
   output logic       regWrite,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] aluOp,
   output logic [1:0] pcSource,
   output logic [3:0] state
`ifdef ILLEGAL_OP_TRAP_EN
   ,
   output logic       illegalOp
`endif
);

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_ALUWB  = 4'd7,
      ST_BRANCH = 4'd8,
      ST_ADDIEX = 4'd9,
      ST_ADDIWB = 4'd10,
      ST_JUMP   = 4'd11
`ifdef ILLEGAL_OP_TRAP_EN
      ,
      ST_TRAP   = 4'd12
`endif
   } state_t;

   state_t state_q;
   state_t state_d;

   // State register. Reset clears it straight away, without waiting for a
   // clock edge. All outputs decode from this register, so the write strobes
   // drop in the same delta and a pending writeback never completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and output decode. Every output is a Moore decode of
   // state_q, with one exception: the FETCH loads (irWrite, pcWrite) are
   // also gated by memReady. They only fire in the cycle the instruction
   // word is actually delivered. The FETCH, MEMRD and MEMWR states hold
   // until memReady is seen. opcode is only looked at in DECODE and MEMADR.
   // IR is stable outside FETCH, so opcode is ignored everywhere else.
   always_comb begin
      state_d     = ST_FETCH;
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      memToReg    = 1'b0;
      regDst      = 1'b0;
      regWrite    = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = 2'b00;
      aluOp       = 2'b00;
      pcSource    = 2'b00;
`ifdef ILLEGAL_OP_TRAP_EN
      illegalOp   = 1'b0;
`endif
      case (state_q)
         ST_FETCH: begin
            memRead = 1'b1;
            aluSrcB = 2'b01;
            irWrite = memReady;
            pcWrite = memReady;
            state_d = memReady ? ST_DECODE : ST_FETCH;
         end
         ST_DECODE: begin
            aluSrcB = 2'b11;
            if (opcode == OP_LW || opcode == OP_SW) begin
               state_d = ST_MEMADR;
            end else if (opcode == OP_RTYPE) begin
               state_d = ST_EXEC;
            end else if (opcode == OP_BEQ) begin
               state_d = ST_BRANCH;
            end else if (opcode == OP_J) begin
               state_d = ST_JUMP;
            end else if (opcode == OP_ADDI) begin
               state_d = ST_ADDIEX;
            end else begin
`ifdef ILLEGAL_OP_TRAP_EN
               state_d = ST_TRAP;
`else
               state_d = ST_FETCH;
`endif
            end
         end
         ST_MEMADR: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
         end
         ST_MEMRD: begin
            memRead = 1'b1;
            iorD    = 1'b1;
            state_d = memReady ? ST_MEMWB : ST_MEMRD;
         end
         ST_MEMWB: begin
            regWrite = 1'b1;
            memToReg = 1'b1;
            state_d  = ST_FETCH;
         end
         ST_MEMWR: begin
            memWrite = 1'b1;
            iorD     = 1'b1;
            state_d  = memReady ? ST_FETCH : ST_MEMWR;
         end
         ST_EXEC: begin
            aluSrcA = 1'b1;
            aluOp   = 2'b10;
            state_d = ST_ALUWB;
         end
         ST_ALUWB: begin
            regWrite = 1'b1;
            regDst   = 1'b1;
            state_d  = ST_FETCH;
         end
         ST_BRANCH: begin
            aluSrcA     = 1'b1;
            aluOp       = 2'b01;
            pcWriteCond = 1'b1;
            pcSource    = 2'b01;
            state_d     = ST_FETCH;
         end
         ST_ADDIEX: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            state_d = ST_ADDIWB;
         end
         ST_ADDIWB: begin
            regWrite = 1'b1;
            state_d  = ST_FETCH;
         end
         ST_JUMP: begin
            pcWrite  = 1'b1;
            pcSource = 2'b10;
            state_d  = ST_FETCH;
         end
`ifdef ILLEGAL_OP_TRAP_EN
         ST_TRAP: begin
            illegalOp = 1'b1;
            state_d   = ST_TRAP;
         end
`endif
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_main_control_fsm
//
// Self-checking bench for main_control_fsm. The first part applies a table
// of per-cycle vectors. Next comes a randomized run of instructions with
// random memory stalls and junk opcodes outside DECODE/MEMADR. The expected
// state sequence is expanded per instruction from its opcode. Last come
// hand-written reset and trap sequences.
// ---------------------------------------------------------------------------
module tb_main_control_fsm;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic       memReady;
   logic       pcWrite;
   logic       pcWriteCond;
   logic       iorD;
   logic       memRead;
   logic       memWrite;
   logic       irWrite;
   logic       memToReg;
   logic       regDst;
   logic       regWrite;
   logic       aluSrcA;
   logic [1:0] aluSrcB;
   logic [1:0] aluOp;
   logic [1:0] pcSource;
   logic [3:0] state;
`ifdef ILLEGAL_OP_TRAP_EN
   logic       illegalOp;
`endif

   int checks = 0;
   int errors = 0;

   main_control_fsm dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .memReady    (memReady),
      .pcWrite     (pcWrite),
      .pcWriteCond (pcWriteCond),
      .iorD        (iorD),
      .memRead     (memRead),
      .memWrite    (memWrite),
      .irWrite     (irWrite),
      .memToReg    (memToReg),
      .regDst      (regDst),
      .regWrite    (regWrite),
      .aluSrcA     (aluSrcA),
      .aluSrcB     (aluSrcB),
      .aluOp       (aluOp),
      .pcSource    (pcSource),
      .state       (state)
`ifdef ILLEGAL_OP_TRAP_EN
      ,
      .illegalOp   (illegalOp)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       pcWrite;
      logic       pcWriteCond;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       memToReg;
      logic       regDst;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic [1:0] pcSource;
   } outs_t;

   outs_t actOuts;
   assign actOuts = '{pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                      memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource};

   // Required output set for each state, taken from the state table.
   function automatic outs_t expOuts(input logic [3:0] st, input logic mr);
      outs_t o;
      o = '0;
      case (st)
         4'd0:  begin o.memRead = 1'b1; o.aluSrcB = 2'b01; o.irWrite = mr; o.pcWrite = mr; end
         4'd1:  o.aluSrcB = 2'b11;
         4'd2:  begin o.aluSrcA = 1'b1; o.aluSrcB = 2'b10; end
         4'd3:  begin o.memRead = 1'b1; o.iorD = 1'b1; end
         4'd4:  begin o.regWrite = 1'b1; o.memToReg = 1'b1; end
         4'd5:  begin o.memWrite = 1'b1; o.iorD = 1'b1; end
         4'd6:  begin o.aluSrcA = 1'b1; o.aluOp = 2'b10; end
         4'd7:  begin o.regWrite = 1'b1; o.regDst = 1'b1; end
         4'd8:  begin o.aluSrcA = 1'b1; o.aluOp = 2'b01; o.pcWriteCond = 1'b1; o.pcSource = 2'b01; end
         4'd9:  begin o.aluSrcA = 1'b1; o.aluSrcB = 2'b10; end
         4'd10: o.regWrite = 1'b1;
         4'd11: begin o.pcWrite = 1'b1; o.pcSource = 2'b10; end
         default: o = '0;
      endcase
      return o;
   endfunction

   function automatic logic isLegal(input logic [5:0] op);
      return (op == 6'h00 || op == 6'h23 || op == 6'h2B ||
              op == 6'h04 || op == 6'h02 || op == 6'h08);
   endfunction

   task automatic applyStimulus(input logic [5:0] op, input logic mr);
      opcode   = op;
      memReady = mr;
   endtask

   // Sample at the falling edge, then move to just after the next rising edge.
   task automatic checkOutput(input logic [3:0] expState, input string tag);
      outs_t e;
      @(negedge clk);
      e = expOuts(expState, memReady);
      checks++;
      if (state !== expState) begin
         errors++;
         $display("[TB] FAIL %s state: got %0d expected %0d", tag, state, expState);
      end
      checks++;
      if (actOuts !== e) begin
         errors++;
         $display("[TB] FAIL %s outputs (state %0d): got %h expected %h", tag, expState, actOuts, e);
      end
`ifdef ILLEGAL_OP_TRAP_EN
      checks++;
      if (illegalOp !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s illegalOp: got %b expected 0", tag, illegalOp);
      end
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic checkBit(input logic act, input logic exp, input string tag);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b", tag, act, exp);
      end
   endtask

   // Reset away from any clock edge, holding memReady low so FETCH is held
   // across the next rising edge.
   task automatic doReset();
      memReady = 1'b0;
      reset    = 1'b1;
      #1;
      checks++;
      if (state !== 4'd0) begin
         errors++;
         $display("[TB] FAIL reset state: got %0d expected 0", state);
      end
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [5:0] op;
      logic       mr;
      logic [3:0] st;
      logic       rw;
      logic       mw;
      logic [1:0] ao;
   } vec_t;

   typedef struct {
      logic [3:0] st;
      logic       mr;
   } step_t;

   vec_t  vecs[$];
   step_t steps[$];

   // Expand one instruction into its per-cycle state and memReady sequence.
   // This includes random stalls in the memory-waiting states.
   task automatic buildInstr(input logic [5:0] op);
      int n;
      n = $urandom_range(0, 2);
      repeat (n) steps.push_back('{st: 4'd0, mr: 1'b0});
      steps.push_back('{st: 4'd0, mr: 1'b1});
      steps.push_back('{st: 4'd1, mr: 1'($urandom)});
      case (op)
         6'h00: begin
            steps.push_back('{st: 4'd6, mr: 1'($urandom)});
            steps.push_back('{st: 4'd7, mr: 1'($urandom)});
         end
         6'h23: begin
            steps.push_back('{st: 4'd2, mr: 1'($urandom)});
            n = $urandom_range(0, 3);
            repeat (n) steps.push_back('{st: 4'd3, mr: 1'b0});
            steps.push_back('{st: 4'd3, mr: 1'b1});
            steps.push_back('{st: 4'd4, mr: 1'($urandom)});
         end
         6'h2B: begin
            steps.push_back('{st: 4'd2, mr: 1'($urandom)});
            n = $urandom_range(0, 3);
            repeat (n) steps.push_back('{st: 4'd5, mr: 1'b0});
            steps.push_back('{st: 4'd5, mr: 1'b1});
         end
         6'h04: steps.push_back('{st: 4'd8, mr: 1'($urandom)});
         6'h02: steps.push_back('{st: 4'd11, mr: 1'($urandom)});
         6'h08: begin
            steps.push_back('{st: 4'd9, mr: 1'($urandom)});
            steps.push_back('{st: 4'd10, mr: 1'($urandom)});
         end
         default: ;
      endcase
   endtask

   // Main test sequence.
   initial begin
      logic [5:0] legalOps [6];
      logic [5:0] op;
      logic [5:0] drv;
      step_t      s;

      legalOps = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};

      // Per-cycle vectors: opcode, memReady, state, regWrite, memWrite, aluOp.
      vecs.push_back('{6'h00, 1'b1, 4'd0,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h00, 1'b1, 4'd1,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h00, 1'b1, 4'd6,  1'b0, 1'b0, 2'b10});
      vecs.push_back('{6'h00, 1'b1, 4'd7,  1'b1, 1'b0, 2'b00});
      vecs.push_back('{6'h23, 1'b1, 4'd0,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h23, 1'b1, 4'd1,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h23, 1'b1, 4'd2,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h23, 1'b0, 4'd3,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h23, 1'b0, 4'd3,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h23, 1'b0, 4'd3,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h23, 1'b1, 4'd3,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h23, 1'b1, 4'd4,  1'b1, 1'b0, 2'b00});
      vecs.push_back('{6'h2B, 1'b1, 4'd0,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h2B, 1'b1, 4'd1,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h2B, 1'b1, 4'd2,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h2B, 1'b1, 4'd5,  1'b0, 1'b1, 2'b00});
      vecs.push_back('{6'h04, 1'b1, 4'd0,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h04, 1'b1, 4'd1,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h04, 1'b1, 4'd8,  1'b0, 1'b0, 2'b01});
      vecs.push_back('{6'h02, 1'b1, 4'd0,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h02, 1'b1, 4'd1,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h02, 1'b1, 4'd11, 1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h08, 1'b0, 4'd0,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h08, 1'b1, 4'd0,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h08, 1'b1, 4'd1,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h08, 1'b1, 4'd9,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h08, 1'b1, 4'd10, 1'b1, 1'b0, 2'b00});
`ifndef ILLEGAL_OP_TRAP_EN
      vecs.push_back('{6'h3F, 1'b1, 4'd0,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h3F, 1'b1, 4'd1,  1'b0, 1'b0, 2'b00});
      vecs.push_back('{6'h3F, 1'b0, 4'd0,  1'b0, 1'b0, 2'b00});
`endif

      // Reset state with memReady high.
      reset    = 1'b1;
      memReady = 1'b1;
      opcode   = 6'h00;
      @(negedge clk);
      checkBit(state == 4'd0, 1'b1, "reset state==0");
      checkBit(memRead,  1'b1, "reset memRead");
      checkBit(irWrite,  1'b1, "reset irWrite");
      checkBit(pcWrite,  1'b1, "reset pcWrite");
      checkBit(aluSrcB == 2'b01, 1'b1, "reset aluSrcB==01");
      checkBit(regWrite, 1'b0, "reset regWrite");
      checkBit(memWrite, 1'b0, "reset memWrite");
      memReady = 1'b0;
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] vector table: %0d entries", vecs.size());
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].op, vecs[i].mr);
         #1;
         checkBit(regWrite, vecs[i].rw, $sformatf("vec%0d regWrite", i));
         checkBit(memWrite, vecs[i].mw, $sformatf("vec%0d memWrite", i));
         checkBit(aluOp == vecs[i].ao, 1'b1, $sformatf("vec%0d aluOp", i));
         checkOutput(vecs[i].st, $sformatf("vec%0d", i));
      end

      // Randomized instruction stream. Junk opcodes appear wherever the
      // FSM must ignore them.
      $display("[TB] random instruction stream");
      for (int k = 0; k < 80; k++) begin
`ifdef ILLEGAL_OP_TRAP_EN
         op = legalOps[$urandom_range(0, 5)];
`else
         if ($urandom_range(0, 6) == 0) begin
            do op = 6'($urandom); while (isLegal(op));
         end else begin
            op = legalOps[$urandom_range(0, 5)];
         end
`endif
         buildInstr(op);
         while (steps.size() > 0) begin
            s   = steps.pop_front();
            drv = (s.st == 4'd1 || s.st == 4'd2) ? op : 6'($urandom);
            applyStimulus(drv, s.mr);
            checkOutput(s.st, $sformatf("rnd%0d op%h", k, op));
         end
      end

      // Reset asserted in MEMWB: regWrite must fall without a clock edge.
      doReset();
      applyStimulus(6'h23, 1'b1);
      checkOutput(4'd0, "lwrst fetch");
      checkOutput(4'd1, "lwrst decode");
      checkOutput(4'd2, "lwrst memadr");
      checkOutput(4'd3, "lwrst memrd");
      checkBit(regWrite, 1'b1, "memwb regWrite before reset");
      reset = 1'b1;
      #1;
      checkBit(regWrite, 1'b0, "memwb regWrite after async reset");
      checkBit(memToReg, 1'b0, "memwb memToReg after async reset");
      checkBit(state == 4'd0, 1'b1, "memwb state==0 after async reset");
      memReady = 1'b0;
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(6'h00, 1'b0);
      checkOutput(4'd0, "after memwb reset");

`ifdef ILLEGAL_OP_TRAP_EN
      // Unrecognised opcode parks the FSM in TRAP until reset.
      applyStimulus(6'h3F, 1'b1);
      checkOutput(4'd0, "trap fetch");
      checkOutput(4'd1, "trap decode");
      for (int t = 0; t < 12; t++) begin
         applyStimulus(6'($urandom), 1'($urandom));
         @(negedge clk);
         checkBit(state == 4'd12, 1'b1, $sformatf("trap%0d state==12", t));
         checkBit(illegalOp, 1'b1, $sformatf("trap%0d illegalOp", t));
         checkBit(actOuts == '0, 1'b1, $sformatf("trap%0d outputs zero", t));
         @(posedge clk);
         #1;
      end
      doReset();
      applyStimulus(6'h00, 1'b0);
      checkOutput(4'd0, "trap cleared");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
